// File: rtl/usb_pkg.sv
// Shared USB receive/transmit definitions: FSM states, sync pattern, CRC-16
// constants and the bit-stuffing run limit.
package usb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HUNT,
    ST_DATA,
    ST_EOP,
    ST_ERR
  } usb_rx_state_e;

  // Decoded sync: zeros followed by a single one (newest bit in the LSB).
  localparam logic [7:0]  SYNC_PATTERN   = 8'b0000_0001;
  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;
  localparam int unsigned STUFF_LIMIT    = 6;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    return {crc[14:0], 1'b0} ^ (((b ^ crc[15]) == 1'b1) ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/usb_rx_fifo.sv
// Small synchronous word FIFO with flush; a push into a full FIFO is dropped
// and flagged unless a pop happens in the same cycle.
module usb_rx_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              valid_o,
  output logic              ovf_o
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [AW:0]       cnt_q;
  logic              empty, full, push, pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign pop   = rd_en_i && !empty && !flush_i;
  assign push  = wr_en_i && (!full || pop) && !flush_i;
  assign ovf_o = wr_en_i && full && !pop && !flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= wr_data_i;
  end

  // Head is masked when empty so stale storage never reaches the output.
  assign rd_data_o = empty ? '0 : mem_q[rd_q];
  assign valid_o   = !empty;

endmodule

// File: rtl/usb_rx_deser.sv
// USB receive deserializer: NRZI decode, sync hunt, bit unstuffing, word
// assembly into usb_rx_fifo. Define USB_RX_CRC16_EN to add CRC-16 checking.
module usb_rx_deser
  import usb_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SYNC_LEN   = 8
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Active,
  input  logic              Data_In,
  input  logic              Diff,
  input  logic              Tx_Ready,
  input  logic              Rd_En,
  output logic [DATA_W-1:0] Data_Out,
  output logic              Rx_Valid,
  output logic              Rx_Ready,
  output logic              Rx_Active,
  output logic              Rx_Error
);

  localparam int unsigned CW = $clog2(DATA_W);
  localparam logic [SYNC_LEN-1:0] SYNC_WORD = SYNC_LEN'(SYNC_PATTERN);

  usb_rx_state_e       state_q, state_d;
  logic                lvl_q;
  logic                dec_bit;
  logic [SYNC_LEN-1:0] sync_q, sync_d;
  logic [DATA_W-2:0]   sh_q, sh_d;
  logic [CW-1:0]       bcnt_q, bcnt_d;
  logic [2:0]          ones_q, ones_d;
  logic                se0_q, se0_d;
  logic                act_q, act_d;
  logic                rdy_q, rdy_d;
  logic                err_q, err_d;
  logic                push;
  logic [DATA_W-1:0]   push_word;
  logic                ovf;
`ifdef USB_RX_CRC16_EN
  logic [15:0]         crc_q, crc_d;
`endif

  assign dec_bit   = (Data_In == lvl_q);
  assign push_word = {dec_bit, sh_q};

  always_comb begin
    state_d = state_q;
    sync_d  = sync_q;
    sh_d    = sh_q;
    bcnt_d  = bcnt_q;
    ones_d  = ones_q;
    se0_d   = se0_q;
    act_d   = act_q;
    err_d   = err_q;
    push    = 1'b0;
`ifdef USB_RX_CRC16_EN
    crc_d   = crc_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // All-ones history keeps idle J (decoded ones) from matching.
        sync_d = '1;
        act_d  = 1'b0;
        if (!Tx_Ready) state_d = ST_HUNT;
      end
      ST_HUNT: begin
        if (Tx_Ready) begin
          state_d = ST_IDLE;
        end else if (Diff) begin
          sync_d = {sync_q[SYNC_LEN-2:0], dec_bit};
          if (sync_d == SYNC_WORD) begin
            state_d = ST_DATA;
            act_d   = 1'b1;
            err_d   = 1'b0;
            sh_d    = '0;
            bcnt_d  = '0;
            ones_d  = '0;
            se0_d   = 1'b0;
`ifdef USB_RX_CRC16_EN
            crc_d   = CRC16_INIT;
`endif
          end
        end
      end
      ST_DATA: begin
        if (!Diff) begin
          if (se0_q) begin
            state_d = ST_EOP;
            se0_d   = 1'b0;
            if (bcnt_q != '0) err_d = 1'b1;
`ifdef USB_RX_CRC16_EN
            if (crc_q != CRC16_RESIDUAL) err_d = 1'b1;
`endif
          end else begin
            se0_d = 1'b1;
          end
        end else if (se0_q || (ones_q == 3'(STUFF_LIMIT) && dec_bit)) begin
          // Lone SE0 or a missing stuffed zero: abandon the packet.
          state_d = ST_ERR;
          act_d   = 1'b0;
          err_d   = 1'b1;
          se0_d   = 1'b0;
        end else if (ones_q == 3'(STUFF_LIMIT)) begin
          ones_d = '0;
        end else begin
          sh_d   = push_word[DATA_W-1:1];
          ones_d = dec_bit ? ones_q + 3'd1 : 3'd0;
`ifdef USB_RX_CRC16_EN
          crc_d  = crc16_step(crc_q, dec_bit);
`endif
          if (bcnt_q == CW'(DATA_W-1)) begin
            push   = 1'b1;
            bcnt_d = '0;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      ST_EOP: begin
        if (Diff) begin
          state_d = ST_IDLE;
          act_d   = 1'b0;
        end
      end
      ST_ERR: begin
        act_d = 1'b0;
        if (!Diff) begin
          if (se0_q) begin
            state_d = ST_IDLE;
            se0_d   = 1'b0;
          end else begin
            se0_d = 1'b1;
          end
        end else begin
          se0_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!Active) begin
      state_d = ST_IDLE;
      act_d   = 1'b0;
      push    = 1'b0;
      se0_d   = 1'b0;
    end
    rdy_d = (state_d == ST_IDLE) || (state_d == ST_HUNT);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      lvl_q   <= 1'b1;
      sync_q  <= '1;
      sh_q    <= '0;
      bcnt_q  <= '0;
      ones_q  <= '0;
      se0_q   <= 1'b0;
      act_q   <= 1'b0;
      rdy_q   <= 1'b1;
      err_q   <= 1'b0;
`ifdef USB_RX_CRC16_EN
      crc_q   <= CRC16_INIT;
`endif
    end else begin
      state_q <= state_d;
      if (Diff) lvl_q <= Data_In;
      sync_q  <= sync_d;
      sh_q    <= sh_d;
      bcnt_q  <= bcnt_d;
      ones_q  <= ones_d;
      se0_q   <= se0_d;
      act_q   <= act_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d | ovf;
`ifdef USB_RX_CRC16_EN
      crc_q   <= crc_d;
`endif
    end
  end

  usb_rx_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (Clk),
    .rst_ni    (Rst_n),
    .flush_i   (!Active),
    .wr_en_i   (push),
    .wr_data_i (push_word),
    .rd_en_i   (Rd_En),
    .rd_data_o (Data_Out),
    .valid_o   (Rx_Valid),
    .ovf_o     (ovf)
  );

  assign Rx_Ready  = rdy_q;
  assign Rx_Active = act_q;
  assign Rx_Error  = err_q;

endmodule

// File: tb/tb_usb_rx_deser.sv
// Directed bench for usb_rx_deser: NRZI/stuffing encoder drives packets,
// each scenario task checks outputs against hand-computed values.
module tb_usb_rx_deser;

  logic       Clk = 1'b0;
  logic       Rst_n, Active, Data_In, Diff, Tx_Ready, Rd_En;
  logic [7:0] Data_Out;
  logic       Rx_Valid, Rx_Ready, Rx_Active, Rx_Error;

  int   checks = 0;
  int   errors = 0;
  logic tb_lvl = 1'b1;
  int   tb_ones = 0;

  usb_rx_deser #(.DATA_W(8), .FIFO_DEPTH(4), .SYNC_LEN(8)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Active(Active), .Data_In(Data_In), .Diff(Diff),
    .Tx_Ready(Tx_Ready), .Rd_En(Rd_En), .Data_Out(Data_Out), .Rx_Valid(Rx_Valid),
    .Rx_Ready(Rx_Ready), .Rx_Active(Rx_Active), .Rx_Error(Rx_Error)
  );

  always #5 Clk = ~Clk;

  // Inputs change on the falling edge; outputs are read on the next falling edge.
  task automatic cyc(input logic d, input logic df);
    Data_In = d;
    Diff    = df;
    @(negedge Clk);
  endtask

  task automatic nrzi(input logic b);
    if (!b) tb_lvl = ~tb_lvl;
    cyc(tb_lvl, 1'b1);
  endtask

  task automatic data_bit(input logic b);
    nrzi(b);
    if (b) begin
      tb_ones++;
      if (tb_ones == 6) begin
        nrzi(1'b0);
        tb_ones = 0;
      end
    end else begin
      tb_ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) data_bit(v[i]);
  endtask

  task automatic idle_j(input int n);
    tb_lvl = 1'b1;
    repeat (n) cyc(1'b1, 1'b1);
  endtask

  task automatic send_sync;
    for (int i = 0; i < 7; i++) nrzi(1'b0);
    nrzi(1'b1);
    tb_ones = 0;
  endtask

  task automatic send_eop;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    tb_lvl = 1'b1;
    cyc(1'b1, 1'b1);
  endtask

  task automatic pop;
    Rd_En = 1'b1;
    @(negedge Clk);
    Rd_En = 1'b0;
  endtask

  task automatic test_reset;
    Rst_n = 1'b0; Active = 1'b1; Tx_Ready = 1'b0; Rd_En = 1'b0;
    Data_In = 1'b1; Diff = 1'b1;
    repeat (3) @(negedge Clk);
    checks++; if (Rx_Ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", Rx_Ready); end
    checks++; if (Rx_Active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b exp 0", Rx_Active); end
    checks++; if (Rx_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", Rx_Valid); end
    checks++; if (Rx_Error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b exp 0", Rx_Error); end
    checks++; if (Data_Out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h exp 00", Data_Out); end
    Rst_n = 1'b1;
    idle_j(3);
  endtask

  task automatic test_basic;
    logic [7:0] v;
    v = 8'hA5;
    idle_j(2);
    send_sync;
    checks++; if (Rx_Active !== 1'b1) begin errors++; $display("FAIL basic_active: got %b exp 1", Rx_Active); end
    checks++; if (Rx_Ready !== 1'b0) begin errors++; $display("FAIL basic_ready_data: got %b exp 0", Rx_Ready); end
    for (int i = 0; i < 7; i++) data_bit(v[i]);
    checks++; if (Rx_Valid !== 1'b0) begin errors++; $display("FAIL basic_valid_early: got %b exp 0", Rx_Valid); end
    data_bit(v[7]);
    checks++; if (Rx_Valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b exp 1", Rx_Valid); end
    checks++; if (Data_Out !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h exp a5", Data_Out); end
    send_eop;
    checks++; if (Rx_Active !== 1'b0) begin errors++; $display("FAIL basic_active_eop: got %b exp 0", Rx_Active); end
    checks++; if (Rx_Error !== 1'b0) begin errors++; $display("FAIL basic_error: got %b exp 0", Rx_Error); end
    checks++; if (Rx_Ready !== 1'b1) begin errors++; $display("FAIL basic_ready_idle: got %b exp 1", Rx_Ready); end
    pop;
    checks++; if (Rx_Valid !== 1'b0) begin errors++; $display("FAIL basic_pop_empty: got %b exp 0", Rx_Valid); end
  endtask

  task automatic test_stuff;
    idle_j(2);
    send_sync;
    send_byte(8'h7F);
    send_byte(8'hFF);
    send_eop;
    checks++; if (Rx_Error !== 1'b0) begin errors++; $display("FAIL stuff_error: got %b exp 0", Rx_Error); end
    checks++; if (Data_Out !== 8'h7F) begin errors++; $display("FAIL stuff_word0: got %h exp 7f", Data_Out); end
    pop;
    checks++; if (Data_Out !== 8'hFF) begin errors++; $display("FAIL stuff_word1: got %h exp ff", Data_Out); end
    pop;
    checks++; if (Rx_Valid !== 1'b0) begin errors++; $display("FAIL stuff_empty: got %b exp 0", Rx_Valid); end
  endtask

  task automatic test_stuff_err;
    idle_j(2);
    send_sync;
    repeat (7) nrzi(1'b1);
    checks++; if (Rx_Error !== 1'b1) begin errors++; $display("FAIL stufferr_error: got %b exp 1", Rx_Error); end
    checks++; if (Rx_Active !== 1'b0) begin errors++; $display("FAIL stufferr_active: got %b exp 0", Rx_Active); end
    checks++; if (Rx_Ready !== 1'b0) begin errors++; $display("FAIL stufferr_in_err: got %b exp 0", Rx_Ready); end
    nrzi(1'b0);
    nrzi(1'b1);
    checks++; if (Rx_Valid !== 1'b0) begin errors++; $display("FAIL stufferr_ignored: got %b exp 0", Rx_Valid); end
    send_eop;
    checks++; if (Rx_Ready !== 1'b1) begin errors++; $display("FAIL stufferr_recover: got %b exp 1", Rx_Ready); end
  endtask

  task automatic test_overflow;
    idle_j(2);
    send_sync;
    checks++; if (Rx_Error !== 1'b0) begin errors++; $display("FAIL ovf_sync_clears: got %b exp 0", Rx_Error); end
    for (int k = 1; k <= 5; k++) send_byte(8'(k));
    checks++; if (Rx_Error !== 1'b1) begin errors++; $display("FAIL ovf_error: got %b exp 1", Rx_Error); end
    send_eop;
    for (int k = 1; k <= 4; k++) begin
      checks++; if (Data_Out !== 8'(k)) begin errors++; $display("FAIL ovf_word%0d: got %h exp %h", k, Data_Out, 8'(k)); end
      pop;
    end
    checks++; if (Rx_Valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b exp 0", Rx_Valid); end
  endtask

  task automatic test_full_pop;
    logic [7:0] v;
    v = 8'h55;
    idle_j(2);
    send_sync;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    for (int i = 0; i < 7; i++) data_bit(v[i]);
    Rd_En = 1'b1;
    data_bit(v[7]);
    Rd_En = 1'b0;
    checks++; if (Rx_Error !== 1'b0) begin errors++; $display("FAIL fullpop_error: got %b exp 0", Rx_Error); end
    checks++; if (Data_Out !== 8'h22) begin errors++; $display("FAIL fullpop_head: got %h exp 22", Data_Out); end
    send_eop;
    pop; pop; pop;
    checks++; if (Data_Out !== 8'h55) begin errors++; $display("FAIL fullpop_last: got %h exp 55", Data_Out); end
    pop;
    checks++; if (Rx_Valid !== 1'b0) begin errors++; $display("FAIL fullpop_empty: got %b exp 0", Rx_Valid); end
  endtask

  task automatic test_align_reset;
    idle_j(2);
    send_sync;
    send_byte(8'h3C);
    data_bit(1'b0); data_bit(1'b1); data_bit(1'b0); data_bit(1'b1);
    send_eop;
    checks++; if (Rx_Error !== 1'b1) begin errors++; $display("FAIL align_error: got %b exp 1", Rx_Error); end
    checks++; if (Data_Out !== 8'h3C) begin errors++; $display("FAIL align_word: got %h exp 3c", Data_Out); end
    idle_j(2);
    send_sync;
    for (int i = 0; i < 5; i++) data_bit(1'b1);
    Rst_n = 1'b0;
    @(negedge Clk);
    checks++; if (Rx_Valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", Rx_Valid); end
    checks++; if (Data_Out !== 8'h00) begin errors++; $display("FAIL rst_data: got %h exp 00", Data_Out); end
    checks++; if (Rx_Error !== 1'b0) begin errors++; $display("FAIL rst_error: got %b exp 0", Rx_Error); end
    checks++; if (Rx_Active !== 1'b0) begin errors++; $display("FAIL rst_active: got %b exp 0", Rx_Active); end
    checks++; if (Rx_Ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b exp 1", Rx_Ready); end
    Rst_n = 1'b1;
    idle_j(4);
    checks++; if (Rx_Valid !== 1'b0) begin errors++; $display("FAIL rst_no_spurious: got %b exp 0", Rx_Valid); end
  endtask

  task automatic test_se0_glitch;
    idle_j(2);
    send_sync;
    data_bit(1'b1); data_bit(1'b0); data_bit(1'b1);
    cyc(1'b0, 1'b0);
    cyc(tb_lvl, 1'b1);
    checks++; if (Rx_Error !== 1'b1) begin errors++; $display("FAIL glitch_error: got %b exp 1", Rx_Error); end
    checks++; if (Rx_Ready !== 1'b0) begin errors++; $display("FAIL glitch_in_err: got %b exp 0", Rx_Ready); end
    send_eop;
    checks++; if (Rx_Ready !== 1'b1) begin errors++; $display("FAIL glitch_recover: got %b exp 1", Rx_Ready); end
  endtask

  task automatic test_active_txready;
    idle_j(2);
    send_sync;
    send_byte(8'h5A);
    checks++; if (Rx_Valid !== 1'b1) begin errors++; $display("FAIL act_word: got %b exp 1", Rx_Valid); end
    Active = 1'b0;
    cyc(tb_lvl, 1'b1);
    checks++; if (Rx_Valid !== 1'b0) begin errors++; $display("FAIL act_flush: got %b exp 0", Rx_Valid); end
    checks++; if (Rx_Active !== 1'b0) begin errors++; $display("FAIL act_rxactive: got %b exp 0", Rx_Active); end
    checks++; if (Rx_Ready !== 1'b1) begin errors++; $display("FAIL act_idle: got %b exp 1", Rx_Ready); end
    Active = 1'b1;
    Tx_Ready = 1'b1;
    idle_j(2);
    send_sync;
    checks++; if (Rx_Active !== 1'b0) begin errors++; $display("FAIL txready_hold: got %b exp 0", Rx_Active); end
    Tx_Ready = 1'b0;
    idle_j(3);
  endtask

`ifdef USB_RX_CRC16_EN
  function automatic logic [15:0] crc_of(input logic [15:0] msg);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < 16; i++) begin
      if (msg[i] ^ c[15]) c = {c[14:0], 1'b0} ^ 16'h8005;
      else                c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  task automatic crc_packet(input logic flip, input logic exp_err);
    logic [15:0] c;
    c = ~crc_of(16'h0100);
    if (flip) c[3] = ~c[3];
    idle_j(2);
    send_sync;
    send_byte(8'h00);
    send_byte(8'h01);
    for (int i = 15; i >= 0; i--) data_bit(c[i]);
    send_eop;
    checks++; if (Rx_Error !== exp_err) begin errors++; $display("FAIL crc_flip%0d: got %b exp %b", flip, Rx_Error, exp_err); end
    Active = 1'b0;
    cyc(1'b1, 1'b1);
    Active = 1'b1;
  endtask

  task automatic test_crc;
    crc_packet(1'b0, 1'b0);
    crc_packet(1'b1, 1'b1);
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_stuff;
    test_stuff_err;
    test_overflow;
    test_full_pop;
    test_align_reset;
    test_se0_glitch;
    test_active_txready;
`ifdef USB_RX_CRC16_EN
    test_crc;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_rx_deser.md
USB_RX_DESER -- requirements
Module: usb_rx_deser

Interface
REQ-001 SHALL have parameter DATA_W, default 8, output word width in bits (8 or 16).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, output word buffer depth (power of two, 2..16).
REQ-003 SHALL have parameter SYNC_LEN, default 8, decoded sync pattern length: SYNC_LEN-1 zeros then a one.
REQ-004 SHALL have port Clk, input, 1, the single clock; one line bit per cycle.
REQ-005 SHALL have port Rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port Active, input, 1, receiver enable; low forces IDLE and flushes the FIFO.
REQ-007 SHALL have port Data_In, input, 1, NRZI line bit (D+ level).
REQ-008 SHALL have port Diff, input, 1, 1 = differential line state, 0 = SE0.
REQ-009 SHALL have port Tx_Ready, input, 1, transmitter busy; high holds the FSM in IDLE.
REQ-010 SHALL have port Rd_En, input, 1, consumer pops the FIFO head when Rx_Valid is high.
REQ-011 SHALL have port Data_Out, output, DATA_W, FIFO head word, LSB first received.
REQ-012 SHALL have port Rx_Valid, output, 1, FIFO not empty.
REQ-013 SHALL have port Rx_Ready, output, 1, high in IDLE/HUNT (able to accept a packet).
REQ-014 SHALL have port Rx_Active, output, 1, high from sync detect until EOP or error.
REQ-015 SHALL have port Rx_Error, output, 1, sticky error flag, cleared at the next sync detect.

Function
REQ-016 SHALL NRZI-decode every Diff=1 cycle: bit = 1 if Data_In equals the previous Data_In, else 0; the previous level resets to 1 (J).
REQ-017 SHALL use FSM states IDLE, HUNT, DATA, EOP, ERR.
REQ-018 IDLE->HUNT when Active=1 and Tx_Ready=0; any state->IDLE within 1 cycle when Active=0.
REQ-019 HUNT->DATA on the cycle the last SYNC_LEN decoded bits match the sync pattern; Rx_Active rises the following cycle.
REQ-020 In DATA, after six consecutive decoded ones the next bit SHALL be discarded if 0; if 1, go to ERR (stuff error).
REQ-021 SHALL shift unstuffed bits LSB-first; on bit DATA_W push the word into the FIFO, so word-to-Rx_Valid latency is 1 cycle with an empty FIFO.
REQ-022 Diff=0 for 2 consecutive cycles -> EOP; Diff=1 in the next cycle -> IDLE with Rx_Active low.
REQ-023 At EOP, a nonzero partial-bit count SHALL set Rx_Error (alignment) and discard the partial word.
REQ-024 A single Diff=0 cycle followed by Diff=1 in DATA -> ERR.
REQ-025 FIFO full on a push: word dropped, Rx_Error set, reception continues.
REQ-026 A simultaneous push and pop when full SHALL succeed, with no error.
REQ-027 Pointers SHALL wrap modulo FIFO_DEPTH; Rd_En with Rx_Valid=0 is ignored.
REQ-028 ERR SHALL hold Rx_Active low, ignore data until a 2-cycle SE0 is seen, then go to IDLE.

Reset
REQ-029 While Rst_n=0: FSM IDLE, FIFO empty, Data_Out=0, Rx_Valid=0, Rx_Ready=1, Rx_Active=0, Rx_Error=0, NRZI level=1, stuff count=0.
REQ-030 Reset asserted mid-packet SHALL discard all buffered and partial data, with no spurious Rx_Valid after release.

Configuration
REQ-031 With USB_RX_CRC16_EN defined: CRC-16 (poly 0x8005, init 0xFFFF) over unstuffed DATA bits; residual not 0x800D at EOP sets Rx_Error; words already pushed remain.
REQ-032 Without USB_RX_CRC16_EN: no CRC logic, and EOP never sets Rx_Error for CRC.

Structure
REQ-033 Shared package usb_pkg SHALL hold the FSM state typedef, the SYNC pattern constant, CRC16_POLY, CRC16_RESIDUAL and STUFF_LIMIT=6.
REQ-034 The FIFO SHALL be sub-module usb_rx_fifo (DATA_W, FIFO_DEPTH), reusable by the transmit side.

Verification
REQ-035 Sync 00000001, then byte 0xA5 (LSB first, NRZI-encoded), then 2xSE0 then J -> Data_Out=0xA5, Rx_Valid 1 cycle after the 8th bit, Rx_Error=0, Rx_Active falls after EOP.
REQ-036 Byte 0x7F followed by 0xFF (bits stuffed by the bench) -> Data_Out 0x7F then 0xFF, no error.
REQ-037 Seven consecutive ones without a stuffed zero -> Rx_Error=1, FSM in ERR, recovery to IDLE after SE0 and J.
REQ-038 FIFO_DEPTH=4, Rd_En=0, 5 bytes 0x01..0x05 -> FIFO holds 0x01..0x04, Rx_Error=1; 4 pops return them in order.
REQ-039 EOP after 12 data bits -> 1 word output, Rx_Error=1; Rst_n pulsed mid-byte -> all outputs at reset values.
REQ-040 With USB_RX_CRC16_EN: 0x00 0x01 plus correct CRC -> Rx_Error=0; one CRC bit flipped -> Rx_Error=1.
